mem_req_arbiter: RTL and testbench

- Shares one req/ack memory slave port between N_REQ requesters (matrix operand fetch, result writeback, loader).
- Round-robin grant; one transaction in flight at a time.
- Latches the winner's address, write enable and write data, drives the slave side, and returns the ack pulse and read data to the winner.
- Sits between compute-side masters and the single memory slave. Data is split into wdata/rdata here; any bidirectional data bus is resolved outside this block.

---
 rtl/mem_arb_pkg.sv | 8 +
 rtl/mem_rr_pick.sv | 22 ++
 rtl/mem_req_arbiter.sv | 114 +++++++++++
 tb/tb_mem_req_arbiter.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: arbiter FSM state type and default sizing shared by the arbiter files.
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} arb_state_t;
    localparam int N_REQ_DEF      = 4;
    localparam int DATA_WIDTH_DEF = 256;
    localparam int ADDR_WIDTH_DEF = 16;
    localparam int TIMEOUT_DEF    = 64;
endpackage

// File: rtl/mem_rr_pick.sv
// mem_rr_pick: combinational round-robin picker, first set request after ptr (wrapping).
module mem_rr_pick
    import mem_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    parameter int IDX_W = $clog2(N_REQ)
)(
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] ptr,
    output logic             found,
    output logic [IDX_W-1:0] idx
);
    logic [N_REQ-1:0] rot;
    // rot[j] is the request of requester (ptr+1+j) mod N_REQ
    always_comb begin
        rot   = N_REQ'({req, req} >> (int'(ptr) + 1));
        found = |rot;
        idx   = '0;
        for (int j = N_REQ - 1; j >= 0; j--)
            if (rot[j]) idx = IDX_W'((int'(ptr) + 1 + j) % N_REQ);
    end
endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: round-robin share of one req/ack memory slave among N_REQ masters.
// Optional ack watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_req_arbiter
    import mem_arb_pkg::*;
#(
    parameter int N_REQ          = N_REQ_DEF,
    parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH     = ADDR_WIDTH_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
    localparam int IDX_W         = $clog2(N_REQ)
)(
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            m_req,
    input  logic [N_REQ-1:0]            m_w_en,
    input  logic [N_REQ*ADDR_WIDTH-1:0] m_addr,
    input  logic [N_REQ*DATA_WIDTH-1:0] m_wdata,
    output logic [N_REQ-1:0]            m_ack,
    output logic [DATA_WIDTH-1:0]       m_rdata,
    output logic                        m_err,
    output logic                        s_req,
    output logic                        s_w_en,
    output logic [ADDR_WIDTH-1:0]       s_addr,
    output logic [DATA_WIDTH-1:0]       s_wdata,
    input  logic                        s_ack,
    input  logic [DATA_WIDTH-1:0]       s_rdata,
    output logic                        grant_valid,
    output logic [IDX_W-1:0]            grant_id
);
    if (N_REQ < 2 || N_REQ > 16 || TIMEOUT_CYCLES < 2) begin : g_bad_cfg
        $error("mem_req_arbiter: N_REQ must be 2..16 and TIMEOUT_CYCLES at least 2");
    end

    arb_state_t       state;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] win;
    logic             found;

    mem_rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
        .req  (m_req),
        .ptr  (ptr),
        .found(found),
        .idx  (win)
    );

`ifdef MEM_ARB_TIMEOUT_EN
    logic [15:0] cnt;
    logic        expire;
    assign expire = cnt == 16'(TIMEOUT_CYCLES - 1);
`else
    assign m_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= IDX_W'(N_REQ - 1);
            s_req       <= 1'b0;
            s_w_en      <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            m_ack       <= '0;
            m_rdata     <= '0;
            grant_valid <= 1'b0;
            grant_id    <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            m_err       <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (found) begin
                    s_w_en      <= m_w_en[win];
                    s_addr      <= m_addr[win*ADDR_WIDTH +: ADDR_WIDTH];
                    s_wdata     <= m_wdata[win*DATA_WIDTH +: DATA_WIDTH];
                    s_req       <= 1'b1;
                    grant_valid <= 1'b1;
                    grant_id    <= win;
                    ptr         <= win;
                    state       <= BUSY;
`ifdef MEM_ARB_TIMEOUT_EN
                    cnt         <= '0;
`endif
                end
                BUSY: if (s_ack) begin
                    m_rdata     <= s_rdata;
                    s_req       <= 1'b0;
                    grant_valid <= 1'b0;
                    m_ack       <= N_REQ'(1) << grant_id;
                    state       <= DONE;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (expire) begin
                    m_rdata     <= '0;
                    s_req       <= 1'b0;
                    grant_valid <= 1'b0;
                    m_ack       <= N_REQ'(1) << grant_id;
                    m_err       <= 1'b1;
                    state       <= DONE;
                end else begin
                    cnt         <= cnt + 16'd1;
                end
`endif
                default: begin
                    m_ack <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
                    m_err <= 1'b0;
`endif
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_req_arbiter.sv
// tb_mem_req_arbiter: directed bench with an ack scoreboard for mem_req_arbiter.
module tb_mem_req_arbiter;
    localparam int N  = 4;
    localparam int DW = 256;
    localparam int AW = 16;

    typedef struct {
        logic [N-1:0]  ack;
        logic [1:0]    id;
        logic [DW-1:0] rd;
        logic          err;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    m_req, m_w_en, m_ack;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_wdata;
    logic [DW-1:0]   m_rdata, s_wdata, s_rdata;
    logic            m_err, s_req, s_w_en, s_ack, grant_valid;
    logic [AW-1:0]   s_addr;
    logic [1:0]      grant_id;

    int   checks = 0;
    int   failures = 0;
    exp_t q[$];
    int   slave_lat = 3;
    logic slave_en = 1'b1;
    logic rearm = 1'b0;
    int   rc[N];
    logic [DW-1:0] a5 = {32{8'hA5}};

    mem_req_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .reset(reset), .m_req(m_req), .m_w_en(m_w_en), .m_addr(m_addr),
        .m_wdata(m_wdata), .m_ack(m_ack), .m_rdata(m_rdata), .m_err(m_err),
        .s_req(s_req), .s_w_en(s_w_en), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_ack(s_ack), .s_rdata(s_rdata), .grant_valid(grant_valid), .grant_id(grant_id)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rd_of(input logic [AW-1:0] a);
        return {16{a ^ 16'h5A5A}};
    endfunction

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int i, input logic [DW-1:0] rd, input logic err);
        exp_t e;
        e.ack = N'(1) << i;
        e.id  = 2'(i);
        e.rd  = rd;
        e.err = err;
        q.push_back(e);
    endtask

    task automatic wait_drain(input int budget);
        int b = 0;
        while (q.size() > 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        if (q.size() > 0) begin
            chk("drain_timeout", DW'(q.size()), '0);
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // slave model: acks slave_lat cycles after s_req rises, data derived from s_addr
    initial begin
        int scnt = 0;
        s_ack = 1'b0;
        s_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (s_ack) begin
                s_ack = 1'b0;
                scnt = 0;
            end else if (slave_en && s_req) begin
                scnt++;
                if (scnt >= slave_lat) begin
                    s_ack = 1'b1;
                    s_rdata = rd_of(s_addr);
                end
            end else scnt = 0;
        end
    end

    // scoreboard check on every master ack; masters drop req right after their ack
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (|m_ack) begin
                if (q.size() == 0) chk("unexpected_ack", DW'(m_ack), '0);
                else begin
                    e = q.pop_front();
                    chk("ack_vec", DW'(m_ack), DW'(e.ack));
                    chk("ack_grant_id", DW'(grant_id), DW'(e.id));
                    chk("ack_rdata", m_rdata, e.rd);
                    chk("ack_err", DW'(m_err), DW'(e.err));
                end
                for (int i = 0; i < N; i++) if (m_ack[i]) begin
                    m_req[i] = 1'b0;
                    if (rearm) rc[i] = 3;
                end
                if (q.size() == 0) begin
                    m_req = '0;
                    rearm = 1'b0;
                end
            end
            for (int i = 0; i < N; i++) if (rc[i] > 0) begin
                rc[i]--;
                if (rc[i] == 0 && rearm) m_req[i] = 1'b1;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, low;
        for (int i = 0; i < N; i++) rc[i] = 0;
        reset = 1'b1;
        m_req = '0;
        m_w_en = '0;
        m_addr = {16'h0103, 16'h0102, 16'h0101, 16'h0010};
        m_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_s_req", DW'(s_req), '0);
        chk("rst_m_ack", DW'(m_ack), '0);
        chk("rst_grant_valid", DW'(grant_valid), '0);
        chk("rst_grant_id", DW'(grant_id), '0);
        chk("rst_s_addr", DW'(s_addr), '0);
        chk("rst_m_rdata", m_rdata, '0);
        chk("rst_m_err", DW'(m_err), '0);
        reset = 1'b0;
        @(negedge clk);

        // single read from requester 0, slave latency 3
        m_req = 4'b0001;
        push(0, rd_of(16'h0010), 1'b0);
        @(posedge clk);
        #1;
        chk("t1_s_req", DW'(s_req), DW'(1));
        chk("t1_s_addr", DW'(s_addr), DW'(16'h0010));
        chk("t1_s_w_en", DW'(s_w_en), '0);
        chk("t1_grant_valid", DW'(grant_valid), DW'(1));
        n = 0;
        for (int b = 0; b < 20 && m_ack == '0; b++) begin
            @(negedge clk);
            if (s_req) n++;
        end
        chk("t1_busy_cycles", DW'(n), DW'(3));
        wait_drain(20);

        // fairness: all request, re-request 2 cycles after ack
        do_reset();
        slave_lat = 2;
        rearm = 1'b1;
        m_req = 4'b1111;
        push(0, rd_of(16'h0010), 1'b0);
        push(1, rd_of(16'h0101), 1'b0);
        push(2, rd_of(16'h0102), 1'b0);
        push(3, rd_of(16'h0103), 1'b0);
        push(0, rd_of(16'h0010), 1'b0);
        wait_drain(100);

        // requester 1 arrives while 2 is busy
        m_req = 4'b0100;
        push(2, rd_of(16'h0102), 1'b0);
        push(1, rd_of(16'h0101), 1'b0);
        @(posedge clk);
        #1;
        chk("t3_first_grant", DW'(grant_id), DW'(2));
        m_req[1] = 1'b1;
        for (int b = 0; b < 20 && !m_ack[2]; b++) @(negedge clk);
        low = 0;
        for (int b = 0; b < 20 && !s_req; b++) begin
            low++;
            @(negedge clk);
        end
        chk("t3_s_req_gap_ge2", DW'(low >= 2), DW'(1));
        chk("t3_second_grant", DW'(grant_id), DW'(1));
        wait_drain(20);

        // stray slave ack while idle
        slave_en = 1'b0;
        s_ack = 1'b1;
        @(negedge clk);
        chk("t4_stray_m_ack", DW'(m_ack), '0);
        @(negedge clk);
        chk("t4_stray_m_ack2", DW'(m_ack), '0);
        chk("t4_stray_grant_valid", DW'(grant_valid), '0);

        // reset in the middle of a transaction
        m_req = 4'b0010;
        @(posedge clk);
        #1;
        chk("t4_busy_s_req", DW'(s_req), DW'(1));
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("t4_rst_s_req", DW'(s_req), '0);
        chk("t4_rst_m_ack", DW'(m_ack), '0);
        chk("t4_rst_grant_valid", DW'(grant_valid), '0);
        m_req = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        slave_en = 1'b1;
        m_req = 4'b0011;
        push(0, rd_of(16'h0010), 1'b0);
        push(1, rd_of(16'h0101), 1'b0);
        wait_drain(40);

        // write from requester 2; other write data toggles during BUSY
        slave_lat = 5;
        m_w_en = 4'b0100;
        m_wdata[2*DW +: DW] = a5;
        m_req = 4'b0100;
        push(2, rd_of(16'h0102), 1'b0);
        @(posedge clk);
        #1;
        for (int b = 0; b < 20 && s_req; b++) begin
            chk("t5_s_w_en", DW'(s_w_en), DW'(1));
            chk("t5_s_wdata", s_wdata, a5);
            for (int i = 0; i < N; i++) if (i != 2) m_wdata[i*DW +: DW] = {8{$urandom()}};
            @(posedge clk);
            #1;
        end
        wait_drain(20);
        m_w_en = '0;

        // slave never acks
        slave_en = 1'b0;
        m_req = 4'b0001;
`ifdef MEM_ARB_TIMEOUT_EN
        push(0, '0, 1'b1);
        @(posedge clk);
        #1;
        n = 0;
        for (int b = 0; b < 50 && s_req; b++) begin
            @(negedge clk);
            if (s_req) n++;
        end
        chk("t6_timeout_busy_cycles", DW'(n), DW'(8));
        wait_drain(10);
`else
        @(posedge clk);
        #1;
        n = 0;
        for (int k = 0; k < 120; k++) begin
            @(negedge clk);
            if (s_req) n++;
        end
        chk("t6_no_timeout_s_req_cycles", DW'(n), DW'(120));
        chk("t6_no_timeout_m_ack", DW'(m_ack), '0);
        chk("t6_no_timeout_m_err", DW'(m_err), '0);
        m_req = '0;
        do_reset();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
